spi_rcv: RTL and testbench
==========================

# spi_rcv

SPI slave receiver that pairs with `spi_gen` on the far end of a link. It oversamples the incoming `clk_spi_in`/`sel_in`/`data_in` pins with the system clock and shifts in MSB-first words, sampling on the rising SPI clock edge (SCLK idles high, `sel` active low). Each completed word is presented as a one-cycle `valid_out` strobe. It sits on the receive side of `spi_interface`, feeding received bytes into the interface's buffer.

## Interface
- `MESSAGE_WIDTH`, 8, bits per word; must be ≥ 2.
- `WORD_CNT_WIDTH`, 8, width of the per-frame word counter.

- `clk_in`  input  1  system clock; all logic on its rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `clk_spi_in`  input  1  SPI clock from the remote host; asynchronous to `clk_in`.
- `sel_in`  input  1  remote chip-select, active low; asynchronous.
- `data_in`  input  1  serial data, MSB first; asynchronous.
- `data_out`  output  MESSAGE_WIDTH  last completed word; holds until the next word completes.
- `valid_out`  output  1  one-cycle strobe when `data_out` is updated.
- `error_out`  output  1  one-cycle strobe when a frame ends with a partial word.
- `busy_out`  output  1  high while in RECV.
- `word_cnt_out`  output  WORD_CNT_WIDTH  words completed in the current frame; wraps modulo 2^WORD_CNT_WIDTH.

## Operation
- Input conditioning: 2-flop synchronizer on each of the three pins, plus a third stage on SCLK and SEL for edge detection. Synchronizer flops reset to 1 (idle line levels).
- Rise event: SCLK sync2 = 1 and sync3 = 0. SEL fall/rise events are defined the same way.
- States:
  - WAIT_HIGH (reset state): ignore everything until synced SEL = 1, then go to IDLE. This prevents locking onto a frame already in progress at reset.
  - IDLE: on a SEL fall event, clear the shift register and bit counter, clear `word_cnt_out`, go to RECV.
  - RECV:
    - On an SCLK rise with SEL still low: shift in synced data (`{shift[W-2:0], d}`) and increment the bit counter.
    - When this is the W-th bit: load `data_out` with the full word, pulse `valid_out`, reset the bit counter to 0, and increment `word_cnt_out`.
    - Back-to-back words within one frame are received with no gap.
  - RECV → IDLE on a SEL rise event. If the bit counter ≠ 0, pulse `error_out` and discard the partial word; `data_out` is unchanged.
- Simultaneous SEL rise and SCLK rise in the same cycle: SEL wins. The bit is not shifted. If the counter was nonzero, or that bit would have completed a word, `error_out` pulses and `valid_out` does not.
- SCLK rise events in IDLE or WAIT_HIGH are ignored.
- `valid_out` and `error_out` are never high in the same cycle.
- Reset at any time: return to WAIT_HIGH. Outputs: `data_out` = 0, `valid_out` = 0, `error_out` = 0, `busy_out` = 0, `word_cnt_out` = 0. Any partial word is lost and no strobe is issued.

## Timing
- Requirement on the remote host: each SCLK level and each SEL level held ≥ 2 `clk_in` cycles. Data must be stable ≥ 2 cycles before an SCLK rise and held through it. `spi_gen` with BIT_DUR ≥ 2 satisfies this.
- Latency: if clk cycle k is the first edge to sample the pin high, the shift/output update occurs at edge k+2. `valid_out` is high for exactly the cycle after edge k+2.
- Data and SCLK pass through equal synchronizer depth, so the sampled bit is the pin value at the SCLK rise ± 1 cycle.
- `busy_out` rises 3 edges after the pin falls (SEL) and falls 3 edges after the pin rises.
- Throughput: one bit per SCLK period; no dead cycles between words.

## Test plan
- Reset, then send one frame with word 0xA5 (SCLK half-period 2 cycles). Expect: `valid_out` for one cycle with `data_out` = 0xA5, `word_cnt_out` = 1, no `error_out`.
- One frame carrying 0x3C then 0xC3 back-to-back. Expect: two `valid_out` strobes, separated by exactly 8 SCLK periods, with `data_out` = 0x3C then 0xC3; `word_cnt_out` reads 2 after the frame.
- SEL raised after 5 bits of 0xFF. Expect: one `error_out` pulse, no `valid_out`, `data_out` keeps its prior value, `busy_out` = 0 afterward.
- `sel_in` held low through reset release, with 3 more bits clocked in, then SEL high, then a full frame of 0x81. Expect: no strobes from the partial traffic; exactly one `valid_out` with 0x81.
- `rst_in` pulsed after bit 4 of a word. Expect: all outputs 0, no strobe. A new frame with 0x5A after SEL goes high then low is received correctly.
- End-to-end with `spi_gen` (BIT_DUR = 2) sending 0x00, 0xFF, 0x96 as three frames. Expect: three `valid_out` strobes with matching `data_out` values, and `error_out` never asserted.

Source files
------------

// File: rtl/spi_rcv.sv
// SPI slave receiver: oversamples SCLK/SEL/DATA with clk_in and shifts in MSB-first words
// on rising SCLK while SEL is low, emitting one-cycle valid/error strobes.
module spi_rcv #(
    parameter int MESSAGE_WIDTH  = 8,
    parameter int WORD_CNT_WIDTH = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      clk_spi_in,
    input  logic                      sel_in,
    input  logic                      data_in,
    output logic [MESSAGE_WIDTH-1:0]  data_out,
    output logic                      valid_out,
    output logic                      error_out,
    output logic                      busy_out,
    output logic [WORD_CNT_WIDTH-1:0] word_cnt_out
);

    localparam int CNT_W = $clog2(MESSAGE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MESSAGE_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        RECV
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                sclk_sync_q, sclk_sync_d;
    logic [2:0]                sel_sync_q, sel_sync_d;
    logic [1:0]                data_sync_q, data_sync_d;
    logic [1:0]                settle_q, settle_d;
    logic [MESSAGE_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [MESSAGE_WIDTH-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      error_q, error_d;
    logic                      busy_q, busy_d;
    logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    logic sclk_rise, sel_rise, sel_fall;

    // Index 1 is the synchronized level, index 2 the previous one used for edge detection.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sel_rise  = sel_sync_q[1] & ~sel_sync_q[2];
    assign sel_fall  = ~sel_sync_q[1] & sel_sync_q[2];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], clk_spi_in};
        sel_sync_d  = {sel_sync_q[1:0], sel_in};
        data_sync_d = {data_sync_q[0], data_in};
        settle_d    = {settle_q[0], 1'b1};
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        word_cnt_d  = word_cnt_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            // The synchronizers hold forced idle levels just after reset; settle_q keeps
            // those from being mistaken for a genuinely high SEL.
            WAIT_HIGH: begin
                if (settle_q[1] && sel_sync_q[1]) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (sel_fall) begin
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (sel_rise) begin
                    error_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (sclk_rise && !sel_sync_q[1]) begin
                    shift_d = {shift_q[MESSAGE_WIDTH-2:0], data_sync_q[1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d     = shift_d;
                        valid_d    = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + WORD_CNT_WIDTH'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= WAIT_HIGH;
            sclk_sync_q <= '1;
            sel_sync_q  <= '1;
            data_sync_q <= '1;
            settle_q    <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            sel_sync_q  <= sel_sync_d;
            data_sync_q <= data_sync_d;
            settle_q    <= settle_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        shift_q <= shift_d;
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign error_out    = error_q;
    assign busy_out     = busy_q;
    assign word_cnt_out = word_cnt_q;

endmodule

// File: tb/tb_spi_rcv.sv
// Bench for spi_rcv: directed frames plus randomized traffic, checked every cycle against
// a word-level model fed with the pin levels the receiver sees two clocks later.
module tb_spi_rcv;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, sclk, sel, dat;
    logic [W-1:0]  data_out;
    logic          valid_out, error_out, busy_out;
    logic [CW-1:0] word_cnt_out;

    spi_rcv #(.MESSAGE_WIDTH(W), .WORD_CNT_WIDTH(CW)) dut (
        .clk_in(clk), .rst_in(rst), .clk_spi_in(sclk), .sel_in(sel), .data_in(dat),
        .data_out(data_out), .valid_out(valid_out), .error_out(error_out),
        .busy_out(busy_out), .word_cnt_out(word_cnt_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins as sampled at each edge, delayed two edges; reset forces idle levels.
    bit h_sclk [4] = '{1, 1, 1, 1};
    bit h_sel  [4] = '{1, 1, 1, 1};
    bit h_dat  [4] = '{1, 1, 1, 1};
    bit h_rst  [4] = '{1, 1, 1, 1};
    int            m_mode = 0;   // 0 waiting for SEL high, 1 idle, 2 receiving
    bit            m_bits[$];
    logic [W-1:0]  m_data = '0;
    bit            m_valid, m_error, m_busy;
    int            m_cnt = 0;
    bit            m_ready = 0;
    int            cyc = 0;
    bit            vs, ps, vc, pc, vd;
    int            word;

    always @(posedge clk) begin
        cyc++;
        for (int i = 3; i > 0; i--) begin
            h_sclk[i] = h_sclk[i-1];
            h_sel[i]  = h_sel[i-1];
            h_dat[i]  = h_dat[i-1];
            h_rst[i]  = h_rst[i-1];
        end
        h_sclk[0] = sclk; h_sel[0] = sel; h_dat[0] = dat; h_rst[0] = rst;
        if (rst) begin
            m_mode = 0; m_bits.delete(); m_data = '0; m_cnt = 0;
            m_valid = 0; m_error = 0; m_busy = 0; m_ready = 1;
        end else begin
            vs = (h_rst[1] || h_rst[2]) ? 1'b1 : h_sel[2];
            ps = (h_rst[1] || h_rst[2] || h_rst[3]) ? 1'b1 : h_sel[3];
            vc = (h_rst[1] || h_rst[2]) ? 1'b1 : h_sclk[2];
            pc = (h_rst[1] || h_rst[2] || h_rst[3]) ? 1'b1 : h_sclk[3];
            vd = (h_rst[1] || h_rst[2]) ? 1'b1 : h_dat[2];
            m_valid = 0;
            m_error = 0;
            if (m_mode == 0) begin
                if (h_sel[2] && !h_rst[1] && !h_rst[2]) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!vs && ps) begin
                    m_bits.delete(); m_cnt = 0; m_mode = 2;
                end
            end else begin
                if (vs && !ps) begin
                    if (m_bits.size() != 0 || (vc && !pc && m_bits.size() == W - 1)) m_error = 1;
                    m_bits.delete();
                    m_mode = 1;
                end else if (vc && !pc && !vs) begin
                    m_bits.push_back(vd);
                    if (m_bits.size() == W) begin
                        word = 0;
                        foreach (m_bits[i]) word = word * 2 + int'(m_bits[i]);
                        m_data = W'(word);
                        m_valid = 1;
                        m_cnt++;
                        m_bits.delete();
                    end
                end
            end
            m_busy = (m_mode == 2);
        end
    end

    // Per-cycle comparison and strobe bookkeeping.
    int           n_valid = 0, n_err = 0;
    int           valid_cyc[$];
    logic [W-1:0] seen[$];

    always @(negedge clk) begin
        if (m_ready) begin
            check("valid", 32'(valid_out), 32'(m_valid));
            check("error", 32'(error_out), 32'(m_error));
            check("busy", 32'(busy_out), 32'(m_busy));
            check("data", 32'(data_out), 32'(m_data));
            check("word_cnt", 32'(word_cnt_out), 32'(CW'(m_cnt)));
            if (valid_out === 1'b1) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                seen.push_back(data_out);
            end
            if (error_out === 1'b1) n_err++;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            dat  = w[W-1-i];
            wait_n(half);
            sclk = 1'b1;
            wait_n(half);
        end
    endtask

    task automatic frame_end(input int half);
        wait_n(half);
        sel = 1'b1;
        wait_n(8);
    endtask

    task automatic frame(input logic [W-1:0] w, input int half);
        sel = 1'b0;
        wait_n(half);
        send_bits(w, W, half);
        frame_end(half);
    endtask

    int bv, be;

    initial begin
        rst = 1'b1; sclk = 1'b1; sel = 1'b1; dat = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(4);
        check("reset_data", 32'(data_out), 32'h0);
        check("reset_busy", 32'(busy_out), 32'h0);
        check("reset_cnt", 32'(word_cnt_out), 32'h0);

        // Single word 0xA5, with busy latency pinned
        bv = n_valid; be = n_err;
        sel = 1'b0;
        wait_n(2);
        check("busy_early", 32'(busy_out), 32'h0);
        wait_n(1);
        check("busy_rise", 32'(busy_out), 32'h1);
        wait_n(1);
        send_bits(8'hA5, W, 2);
        frame_end(2);
        check("a5_nvalid", 32'(n_valid - bv), 32'd1);
        check("a5_data", 32'(seen[$]), 32'hA5);
        check("a5_cnt", 32'(word_cnt_out), 32'd1);
        check("a5_nerr", 32'(n_err - be), 32'd0);

        // Back-to-back 0x3C, 0xC3
        bv = n_valid;
        sel = 1'b0;
        wait_n(2);
        send_bits(8'h3C, W, 2);
        send_bits(8'hC3, W, 2);
        frame_end(2);
        check("b2b_nvalid", 32'(n_valid - bv), 32'd2);
        check("b2b_first", 32'(seen[$-1]), 32'h3C);
        check("b2b_second", 32'(seen[$]), 32'hC3);
        check("b2b_spacing", 32'(valid_cyc[$] - valid_cyc[$-1]), 32'd32);
        check("b2b_cnt", 32'(word_cnt_out), 32'd2);

        // Partial word: 5 bits of 0xFF
        bv = n_valid; be = n_err;
        sel = 1'b0;
        wait_n(2);
        send_bits(8'hFF, 5, 2);
        frame_end(2);
        check("part_nerr", 32'(n_err - be), 32'd1);
        check("part_nvalid", 32'(n_valid - bv), 32'd0);
        check("part_data", 32'(data_out), 32'hC3);
        check("part_busy", 32'(busy_out), 32'h0);

        // SEL low across reset release, partial traffic, then 0x81
        bv = n_valid; be = n_err;
        rst = 1'b1; sel = 1'b0;
        wait_n(3);
        rst = 1'b0;
        send_bits(8'hE0, 3, 2);
        wait_n(2);
        sel = 1'b1;
        wait_n(8);
        frame(8'h81, 2);
        check("lock_nvalid", 32'(n_valid - bv), 32'd1);
        check("lock_data", 32'(seen[$]), 32'h81);
        check("lock_nerr", 32'(n_err - be), 32'd0);

        // Reset after bit 4, then 0x5A
        bv = n_valid; be = n_err;
        sel = 1'b0;
        wait_n(2);
        send_bits(8'hF0, 4, 2);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(4);
        check("midrst_data", 32'(data_out), 32'h0);
        check("midrst_cnt", 32'(word_cnt_out), 32'h0);
        check("midrst_busy", 32'(busy_out), 32'h0);
        sel = 1'b1;
        wait_n(8);
        frame(8'h5A, 2);
        check("midrst_nvalid", 32'(n_valid - bv), 32'd1);
        check("midrst_new", 32'(seen[$]), 32'h5A);
        check("midrst_nerr", 32'(n_err - be), 32'd0);

        // Three frames as a BIT_DUR=2 generator would send them
        bv = n_valid; be = n_err;
        frame(8'h00, 2);
        frame(8'hFF, 2);
        frame(8'h96, 2);
        check("e2e_nvalid", 32'(n_valid - bv), 32'd3);
        check("e2e_w0", 32'(seen[$-2]), 32'h00);
        check("e2e_w1", 32'(seen[$-1]), 32'hFF);
        check("e2e_w2", 32'(seen[$]), 32'h96);
        check("e2e_nerr", 32'(n_err - be), 32'd0);

        // SEL rise coincides with the SCLK rise of the 8th bit
        bv = n_valid; be = n_err;
        sel = 1'b0;
        wait_n(2);
        send_bits(8'hAB, 7, 2);
        sclk = 1'b0; dat = 1'b1;
        wait_n(2);
        sclk = 1'b1; sel = 1'b1;
        wait_n(8);
        check("coinc_nerr", 32'(n_err - be), 32'd1);
        check("coinc_nvalid", 32'(n_valid - bv), 32'd0);
        check("coinc_data", 32'(data_out), 32'h96);

        // Randomized frames, partial words and idle resets
        for (int it = 0; it < 40; it++) begin
            int half, nw, extra;
            half = $urandom_range(2, 4);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                wait_n($urandom_range(1, 2));
                rst = 1'b0;
                wait_n(4);
            end
            nw    = $urandom_range(0, 3);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            sel = 1'b0;
            wait_n(half);
            for (int k = 0; k < nw; k++) send_bits(W'($urandom), W, half);
            send_bits(W'($urandom), extra, half);
            frame_end(half);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
